// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity-type encoding (common with the transmitter).
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit a correct transmitter sends, given the XOR of the data bits.
  function automatic logic par_expected(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side link: serial line and frame options in, recovered word and status pulses out.
interface uart_rx_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             RX_IN;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_ERR;
  logic             STP_ERR;
  logic             Busy;

  // Receiver side.
  modport master (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );

  // Line driver / downstream consumer side.
  modport slave (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );

endinterface

// File: rtl/data_sampling.sv
// Three-sample majority voter around mid-bit; decision is presented on the third sample cycle.
module data_sampling #(
  parameter  int unsigned PRESCALE = 8,
  localparam int unsigned ECW      = $clog2(PRESCALE)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           rx_s,
  input  logic [ECW-1:0] edge_cnt,
  output logic           sampled_bit,
  output logic           sample_done
);

  localparam int unsigned MID = PRESCALE / 2;

  logic s0;
  logic s1;

  // Capture the first two samples; the third is used live on the decision tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (edge_cnt == ECW'(MID - 1)) s0 <= rx_s;
      if (edge_cnt == ECW'(MID))     s1 <= rx_s;
    end
  end

  // Majority of the three samples, valid while edge_cnt sits on the decision tick.
  always_comb begin
    sample_done = (edge_cnt == ECW'(MID + 1));
    sampled_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional parity/stop, registered word and status pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 8
) (
  input logic       CLK,
  input logic       RST,
  uart_rx_if.master bus
);

  localparam int unsigned ECW = $clog2(PRESCALE);
  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state;
  state_e           state_n;
  logic             rx_meta;
  logic             rx_s;
  logic [ECW-1:0]   edge_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             par_en_l;
  logic             par_typ_l;
  logic             par_bad;
  logic             sampled_bit;
  logic             sample_done;
  logic             edge_wrap;
  logic             bit_last;

  logic [WIDTH-1:0] p_data_q;
  logic [WIDTH-1:0] p_data_n;
  logic             valid_q;
  logic             valid_n;
  logic             par_err_q;
  logic             par_err_n;
  logic             stp_err_q;
  logic             stp_err_n;
  logic             busy_q;
  logic             busy_n;

  assign edge_wrap = (edge_cnt == ECW'(PRESCALE - 1));
  assign bit_last  = (bit_cnt == BCW'(WIDTH - 1));

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_s    <= rx_meta;
    end
  end

  data_sampling #(.PRESCALE(PRESCALE)) u_sampling (
    .CLK         (CLK),
    .RST         (RST),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; STOP leaves on its decision tick so a back-to-back start edge is caught.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!rx_s) state_n = START;
      START: begin
        if (sample_done && sampled_bit) state_n = IDLE;
        else if (edge_wrap)             state_n = DATA;
      end
      DATA:    if (edge_wrap && bit_last) state_n = par_en_l ? PARITY : STOP;
      PARITY:  if (edge_wrap) state_n = STOP;
      STOP:    if (sample_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; the frame outcome is resolved on the stop decision tick.
  always_comb begin
    valid_n   = 1'b0;
    par_err_n = 1'b0;
    stp_err_n = 1'b0;
    p_data_n  = p_data_q;
    busy_n    = (state_n != IDLE);
    if (state == STOP && sample_done) begin
      valid_n   = sampled_bit & ~par_bad;
      par_err_n = par_bad;
      stp_err_n = ~sampled_bit;
      if (sampled_bit && !par_bad) p_data_n = shift_reg;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      p_data_q  <= p_data_n;
      valid_q   <= valid_n;
      par_err_q <= par_err_n;
      stp_err_q <= stp_err_n;
      busy_q    <= busy_n;
    end
  end

  // Bit timing counters, data shift register and per-frame parity bookkeeping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= PAR_EVEN;
      par_bad   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        edge_cnt <= rx_s ? '0 : ECW'(1);
        bit_cnt  <= '0;
      end else begin
        edge_cnt <= edge_wrap ? '0 : edge_cnt + ECW'(1);
      end
      case (state)
        START: begin
          if (sample_done && !sampled_bit) begin
            par_en_l  <= bus.PAR_EN;
            par_typ_l <= bus.PAR_TYP;
            par_bad   <= 1'b0;
          end
        end
        DATA: begin
          if (sample_done) shift_reg[bit_cnt] <= sampled_bit;
          if (edge_wrap)   bit_cnt <= bit_last ? '0 : bit_cnt + BCW'(1);
        end
        PARITY: begin
          if (sample_done) par_bad <= (sampled_bit != par_expected(^shift_reg, par_typ_l));
        end
        default: ;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.PAR_ERR    = par_err_q;
  assign bus.STP_ERR    = stp_err_q;
  assign bus.Busy       = busy_q;

endmodule
